id_stage: RTL

- RV32I decode stage. Sits between the IF/ID latch and the EX stage, and drives the two read ports of the register file.
- Decodes the instruction and generates the immediate.
- Selects operands from the register file, or forwards them from EX/MEM.
- Detects load-use hazards and registers the decoded bundle into the ID/EX pipeline register consumed by EX.

---
 rtl/rv_pkg.sv | 47 ++++
 rtl/imm_gen.sv | 30 +++
 rtl/id_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// RV32I decode constants shared by the ID stage and its immediate generator.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_JAL, ALU_JALR
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_e;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  function automatic alu_op_e alu_arith(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator, sign-extended to XLEN.
module imm_gen
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = rv_pkg::XLEN
) (
  input  logic [31:0]     i_inst,
  input  logic [2:0]      i_fmt,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm;

  always_comb begin
    w_imm = '0;
    case (fmt_e'(i_fmt))
      FMT_I: w_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      FMT_S: w_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FMT_B: w_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                      i_inst[11:8], 1'b0};
      FMT_U: w_imm = {i_inst[31:12], 12'b0};
      FMT_J: w_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                      i_inst[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  assign o_imm = XLEN'($signed(w_imm));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, immediate, operand forwarding, load-use
// detection and the ID/EX pipeline register.
module id_stage
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [31:0]     id_inst_i,
  output logic [4:0]      ra1_o,
  output logic            re1_o,
  input  logic [XLEN-1:0] rn1_i,
  output logic [4:0]      ra2_o,
  output logic            re2_o,
  input  logic [XLEN-1:0] rn2_i,
  input  logic [4:0]      ex_wa_i,
  input  logic            ex_we_i,
  input  logic [XLEN-1:0] ex_wn_i,
  input  logic            ex_is_load_i,
  input  logic [4:0]      mem_wa_i,
  input  logic            mem_we_i,
  input  logic [XLEN-1:0] mem_wn_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [4:0]      ex_aluop_o,
  output logic [XLEN-1:0] ex_op1_o,
  output logic [XLEN-1:0] ex_op2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic            ex_use_imm_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_we_o,
  output logic [1:0]      ex_mem_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_illegal_o
);

  logic [31:0]     w_inst;
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  fmt_e            w_fmt;
  alu_op_e         w_alu;
  mem_op_e         w_mem;
  logic            w_use_imm, w_we, w_illegal, w_op1_pc, w_op1_zero;
  logic [XLEN-1:0] w_imm, w_fwd1, w_fwd2, w_op1;

  // An empty IF/ID slot decodes as a NOP so stale words never raise illegal.
  assign w_inst = id_valid_i ? id_inst_i : NOP;
  assign w_opc  = w_inst[6:0];
  assign w_f3   = w_inst[14:12];
  assign w_f7   = w_inst[31:25];

  always_comb begin
    w_fmt = FMT_NONE; w_alu = ALU_ADD; w_mem = MEM_NONE;
    w_use_imm = 1'b0; w_we = 1'b0; w_illegal = 1'b0;
    w_op1_pc = 1'b0; w_op1_zero = 1'b0;
    case (w_opc)
      OP: begin
        w_fmt = FMT_R; w_we = 1'b1; w_alu = alu_arith(w_f3, w_f7[5]);
        w_illegal = !(w_f7 == 7'b0 ||
                      (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      OP_IMM: begin
        w_fmt = FMT_I; w_we = 1'b1; w_use_imm = 1'b1;
        w_alu = alu_arith(w_f3, (w_f3 == 3'b101) && w_f7[5]);
        w_illegal = (w_f3 == 3'b001 && w_f7 != 7'b0) ||
                    (w_f3 == 3'b101 && w_f7 != 7'b0 && w_f7 != 7'b0100000);
      end
      LOAD: begin
        w_fmt = FMT_I; w_we = 1'b1; w_use_imm = 1'b1; w_mem = MEM_LOAD;
        w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      STORE: begin
        w_fmt = FMT_S; w_use_imm = 1'b1; w_mem = MEM_STORE;
        w_illegal = (w_f3 > 3'b010);
      end
      BRANCH: begin
        w_fmt = FMT_B;
        case (w_f3)
          3'b000:  w_alu = ALU_BEQ;
          3'b001:  w_alu = ALU_BNE;
          3'b100:  w_alu = ALU_BLT;
          3'b101:  w_alu = ALU_BGE;
          3'b110:  w_alu = ALU_BLTU;
          3'b111:  w_alu = ALU_BGEU;
          default: w_illegal = 1'b1;
        endcase
      end
      JAL: begin
        w_fmt = FMT_J; w_we = 1'b1; w_use_imm = 1'b1; w_op1_pc = 1'b1; w_alu = ALU_JAL;
      end
      JALR: begin
        w_fmt = FMT_I; w_we = 1'b1; w_use_imm = 1'b1; w_op1_pc = 1'b1; w_alu = ALU_JALR;
        w_illegal = (w_f3 != 3'b000);
      end
      LUI: begin
        w_fmt = FMT_U; w_we = 1'b1; w_use_imm = 1'b1; w_op1_zero = 1'b1;
      end
      AUIPC: begin
        w_fmt = FMT_U; w_we = 1'b1; w_use_imm = 1'b1; w_op1_pc = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_fmt = FMT_NONE; w_alu = ALU_ADD; w_mem = MEM_NONE;
      w_use_imm = 1'b0; w_we = 1'b0; w_op1_pc = 1'b0; w_op1_zero = 1'b0;
    end
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_inst (w_inst),
    .i_fmt  (w_fmt),
    .o_imm  (w_imm)
  );

  assign ra1_o = id_inst_i[19:15];
  assign ra2_o = id_inst_i[24:20];
  assign re1_o = id_valid_i &
                 (w_fmt == FMT_R || w_fmt == FMT_I || w_fmt == FMT_S || w_fmt == FMT_B);
  assign re2_o = id_valid_i & (w_fmt == FMT_R || w_fmt == FMT_S || w_fmt == FMT_B);

  // A load in EX has no data yet; that case is covered by stall_req_o instead.
  always_comb begin
    w_fwd1 = rn1_i;
    if (!re1_o || ra1_o == 5'd0)                          w_fwd1 = '0;
    else if (ex_we_i && ex_wa_i == ra1_o && !ex_is_load_i) w_fwd1 = ex_wn_i;
    else if (mem_we_i && mem_wa_i == ra1_o)                w_fwd1 = mem_wn_i;
    w_fwd2 = rn2_i;
    if (!re2_o || ra2_o == 5'd0)                          w_fwd2 = '0;
    else if (ex_we_i && ex_wa_i == ra2_o && !ex_is_load_i) w_fwd2 = ex_wn_i;
    else if (mem_we_i && mem_wa_i == ra2_o)                w_fwd2 = mem_wn_i;
  end

  assign w_op1 = w_op1_zero ? '0 : (w_op1_pc ? id_pc_i : w_fwd1);

  assign stall_req_o = id_valid_i & ex_is_load_i & ex_we_i & (ex_wa_i != 5'd0) &
                       ((re1_o & (ex_wa_i == ra1_o)) | (re2_o & (ex_wa_i == ra2_o)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_o <= 1'b0;  ex_pc_o <= RESET_PC;  ex_aluop_o <= '0;
      ex_op1_o <= '0;      ex_op2_o <= '0;       ex_imm_o <= '0;
      ex_use_imm_o <= 1'b0; ex_rd_o <= '0;       ex_we_o <= 1'b0;
      ex_mem_o <= '0;      ex_funct3_o <= '0;    ex_illegal_o <= 1'b0;
    end else if (stall_i) begin
      ex_valid_o <= ex_valid_o;
    end else if (flush_i || stall_req_o) begin
      ex_valid_o <= 1'b0; ex_we_o <= 1'b0; ex_mem_o <= '0; ex_illegal_o <= 1'b0;
    end else begin
      ex_valid_o   <= id_valid_i;
      ex_pc_o      <= id_pc_i;
      ex_aluop_o   <= w_alu;
      ex_op1_o     <= w_op1;
      ex_op2_o     <= w_fwd2;
      ex_imm_o     <= w_imm;
      ex_use_imm_o <= w_use_imm;
      ex_rd_o      <= w_inst[11:7];
      ex_we_o      <= id_valid_i & w_we & (w_inst[11:7] != 5'd0);
      ex_mem_o     <= id_valid_i ? w_mem : MEM_NONE;
      ex_funct3_o  <= w_f3;
      ex_illegal_o <= id_valid_i & w_illegal;
    end
  end

endmodule
